jtframe_sdram_arb: RTL



---
 rtl/jtframe_sdram_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: multi-slot SDRAM arbiter.
// Grants one client slot at a time, forwards its command to the SDRAM
// controller and returns the result with a held one-hot select plus a
// one-cycle completion strobe.
// Optional feature: define JTFRAME_SDRAM_ARB_RR_EN for round-robin priority;
// the default build uses fixed priority (lowest slot index wins).
module jtframe_sdram_arb #(
  parameter int SLOTS = 4,
  parameter int IW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS-1:0]      slot_rnw,
  input  logic [SLOTS*22-1:0]   slot_addr,
  input  logic [SLOTS*32-1:0]   slot_wrdata,
  output logic [SLOTS-1:0]      slot_sel,
  output logic [31:0]           slot_din,
  output logic                  slot_din_ok,
  output logic                  ctl_req,
  output logic                  ctl_rnw,
  output logic [21:0]           ctl_addr,
  output logic [31:0]           ctl_wrdata,
  input  logic                  ctl_ack,
  input  logic                  ctl_rdy,
  input  logic [31:0]           ctl_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DATA,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SLOTS-1:0]  sel_q, sel_d;
  logic [31:0]       din_q, din_d;
  logic              din_ok_q, din_ok_d;
  logic              req_q, req_d;
  logic              rnw_q, rnw_d;
  logic [21:0]       addr_q, addr_d;
  logic [31:0]       wrdata_q, wrdata_d;

  logic [IW-1:0]     grant_idx;
  logic              any_req;

`ifdef JTFRAME_SDRAM_ARB_RR_EN
  logic [IW-1:0]     last_q, last_d;

  // Round-robin winner: first requesting slot searching upward from last+1.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    any_req   = |slot_req;
    grant_idx = '0;
    // Walk from farthest to nearest so the slot closest to last+1 wins.
    for (int k = SLOTS; k >= 1; k--) begin
      if (slot_req[(int'(last_q) + k) % SLOTS]) begin
        grant_idx = IW'((int'(last_q) + k) % SLOTS);
      end
    end
  end
`else
  // Fixed-priority winner: lowest requesting index.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    any_req   = |slot_req;
    grant_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_req[i]) begin
        grant_idx = IW'(i);
      end
    end
  end
`endif

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    din_d    = din_q;
    din_ok_d = din_ok_q;
    req_d    = req_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
`ifdef JTFRAME_SDRAM_ARB_RR_EN
    last_d   = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d  = S_WAIT_ACK;
          sel_d    = SLOTS'(1) << grant_idx;
          req_d    = 1'b1;
          rnw_d    = slot_rnw[grant_idx];
          addr_d   = slot_addr[22*grant_idx +: 22];
          wrdata_d = slot_wrdata[32*grant_idx +: 32];
`ifdef JTFRAME_SDRAM_ARB_RR_EN
          last_d   = grant_idx;
`endif
        end
      end

      S_WAIT_ACK: begin
        if (ctl_ack) begin
          req_d = 1'b0;
          if (ctl_rdy) begin
            // Controller finished in the same cycle it accepted the command.
            state_d  = S_DONE;
            din_ok_d = 1'b1;
            if (rnw_q) din_d = ctl_dout;
          end else begin
            state_d = S_WAIT_DATA;
          end
        end
      end

      S_WAIT_DATA: begin
        if (ctl_rdy) begin
          state_d  = S_DONE;
          din_ok_d = 1'b1;
          // Writes keep the previous read data visible to the slots.
          if (rnw_q) din_d = ctl_dout;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        din_ok_d = 1'b0;
        sel_d    = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      din_q    <= '0;
      din_ok_q <= 1'b0;
      req_q    <= 1'b0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      sel_q    <= sel_d;
      din_q    <= din_d;
      din_ok_q <= din_ok_d;
      req_q    <= req_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

`ifdef JTFRAME_SDRAM_ARB_RR_EN
  // Round-robin pointer; starts at the top slot so slot 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(SLOTS - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign slot_sel    = sel_q;
  assign slot_din    = din_q;
  assign slot_din_ok = din_ok_q;
  assign ctl_req     = req_q;
  assign ctl_rnw     = rnw_q;
  assign ctl_addr    = addr_q;
  assign ctl_wrdata  = wrdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule
